// File: rtl/gnn_0_load_axi_read_master.sv
// AXI4 read master feeding the load stage: splits a byte transfer into 4 KB-safe
// AR bursts, buffers R beats in a FWFT FIFO and streams them out with tlast.
//
// state  | meaning
// -------|-----------------------------------------------------------
// IDLE   | waiting for read_start
// RUN    | issuing AR bursts, filling the FIFO, streaming beats out
// FINISH | transfer consumed; read_done pulses for one cycle
module gnn_0_load_axi_read_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BURST_LEN        = 64,
    parameter int C_FIFO_DEPTH       = 512
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          read_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
    output logic                          read_done,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          data_tvalid,
    input  logic                          data_tready,
    output logic                          data_tlast,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int BW = C_XFER_SIZE_WIDTH + 1;
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AW-1:0] r_addr;
    logic [BW-1:0] r_beats;
    logic [BW-1:0] r_ar_remaining;
    logic [BW-1:0] r_pop_cnt;
    logic [CW-1:0] r_credits;
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [C_FIFO_DEPTH];

    logic          w_load;
    logic [BW-1:0] w_size_ext;
    logic [BW-1:0] w_start_beats;
    logic [8:0]    w_rem_cap;
    logic [8:0]    w_page_beats;
    logic [8:0]    w_n;
    logic          w_ar_active;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic          w_pop;
    logic [BW-1:0] w_pop_num;
    logic          w_pop_last;
    logic          w_full;
    logic          w_empty;
    logic          w_unused_rlast;

    // rlast is accepted but framing comes purely from the beat count
    assign w_unused_rlast = m_axi_rlast;

    assign w_size_ext    = {1'b0, dram_xfer_size_in_bytes} + BW'(63);
    assign w_start_beats = w_size_ext >> 6;

    // Burst length: remaining beats, capped by max burst and by the 4 KB page edge
    assign w_rem_cap    = (r_ar_remaining > BW'(C_BURST_LEN)) ? 9'(C_BURST_LEN)
                                                               : r_ar_remaining[8:0];
    assign w_page_beats = 9'd64 - {3'b000, r_addr[11:6]};
    assign w_n          = (w_page_beats < w_rem_cap) ? w_page_beats : w_rem_cap;

    assign w_ar_active   = (r_state == S_RUN) && (r_ar_remaining != '0);
    assign m_axi_arvalid = w_ar_active && (r_credits >= CW'(w_n));
    assign m_axi_araddr  = w_ar_active ? r_addr : '0;
    assign m_axi_arlen   = w_ar_active ? 8'(w_n - 9'd1) : 8'd0;
    assign w_ar_hs       = m_axi_arvalid && m_axi_arready;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

    assign m_axi_rready = (r_state == S_RUN) && !w_full;
    assign w_r_hs       = m_axi_rvalid && m_axi_rready;

    assign data_tvalid = (r_state == S_RUN) && !w_empty;
    assign data_tdata  = data_tvalid ? r_mem[r_rd_ptr[PW-1:0]] : '0;
    assign w_pop       = data_tvalid && data_tready;
    assign w_pop_num   = r_pop_cnt + BW'(1);
    assign w_pop_last  = (w_pop_num == r_beats);
    assign data_tlast  = data_tvalid && w_pop_last;

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        read_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (read_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (w_start_beats == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (w_pop && w_pop_last) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                read_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_addr         <= '0;
            r_beats        <= '0;
            r_ar_remaining <= '0;
            r_pop_cnt      <= '0;
            r_credits      <= CW'(C_FIFO_DEPTH);
        end else if (w_load) begin
            r_addr         <= dram_xfer_start_addr & ~AW'(63);
            r_beats        <= w_start_beats;
            r_ar_remaining <= w_start_beats;
            r_pop_cnt      <= '0;
            r_credits      <= CW'(C_FIFO_DEPTH);
        end else begin
            if (w_ar_hs) begin
                r_addr         <= r_addr + AW'({w_n, 6'b000000});
                r_ar_remaining <= r_ar_remaining - BW'(w_n);
            end
            if (w_pop) begin
                r_pop_cnt <= w_pop_num;
            end
            // A burst reservation and a pop in the same cycle both apply
            r_credits <= r_credits - (w_ar_hs ? CW'(w_n) : CW'(0))
                                   + (w_pop ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_r_hs) begin
                r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge kernel_clk) begin
        if (w_r_hs) begin
            r_mem[r_wr_ptr[PW-1:0]] <= m_axi_rdata;
        end
    end

endmodule

// File: tb/tb_gnn_0_load_axi_read_master.sv
// Directed bench for gnn_0_load_axi_read_master: a simple AXI slave returns the
// beat address replicated across the data word; each test task checks its own results.
module tb_gnn_0_load_axi_read_master;

    logic         kernel_clk = 1'b0;
    logic         kernel_rst_n = 1'b0;
    logic         read_start = 1'b0;
    logic [63:0]  dram_xfer_start_addr = '0;
    logic [31:0]  dram_xfer_size_in_bytes = '0;
    logic         read_done;
    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b0;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;
    logic [511:0] m_axi_rdata = '0;
    logic         m_axi_rlast = 1'b0;
    logic         data_tvalid;
    logic         data_tready = 1'b0;
    logic         data_tlast;
    logic [511:0] data_tdata;

    gnn_0_load_axi_read_master dut (
        .kernel_clk              (kernel_clk),
        .kernel_rst_n            (kernel_rst_n),
        .read_start              (read_start),
        .dram_xfer_start_addr    (dram_xfer_start_addr),
        .dram_xfer_size_in_bytes (dram_xfer_size_in_bytes),
        .read_done               (read_done),
        .m_axi_arvalid           (m_axi_arvalid),
        .m_axi_arready           (m_axi_arready),
        .m_axi_araddr            (m_axi_araddr),
        .m_axi_arlen             (m_axi_arlen),
        .m_axi_rvalid            (m_axi_rvalid),
        .m_axi_rready            (m_axi_rready),
        .m_axi_rdata             (m_axi_rdata),
        .m_axi_rlast             (m_axi_rlast),
        .data_tvalid             (data_tvalid),
        .data_tready             (data_tready),
        .data_tlast              (data_tlast),
        .data_tdata              (data_tdata)
    );

    initial begin
        forever #5 kernel_clk = ~kernel_clk;
    end

    int checks = 0;
    int errors = 0;

    logic ar_ready_en = 1'b1;
    logic tready_en   = 1'b1;

    int cyc = 0;
    int start_cyc, first_ar_cyc, first_r_cyc, first_tv_cyc, first_pop_cyc, last_pop_cyc;
    int done_cyc, done_cnt, r_cnt;
    logic [63:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [63:0] pop_data_q[$];
    logic        pop_last_q[$];
    logic [63:0] rq[$];
    logic        rq_last[$];

    // Slave + monitor: drive on the falling edge, sample 1 time unit later;
    // every sampled handshake belongs to the following rising edge.
    initial begin
        forever begin
            @(negedge kernel_clk);
            cyc++;
            m_axi_arready = ar_ready_en;
            data_tready   = tready_en;
            if (rq.size() != 0) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = {8{rq[0]}};
                m_axi_rlast  = rq_last[0];
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rdata  = '0;
                m_axi_rlast  = 1'b0;
            end
            #1;
            if (read_start) begin
                start_cyc     = cyc;
                first_ar_cyc  = -1;
                first_r_cyc   = -1;
                first_tv_cyc  = -1;
                first_pop_cyc = -1;
            end
            if (m_axi_arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
            if (data_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
            if (m_axi_rvalid && m_axi_rready) begin
                rq.delete(0);
                rq_last.delete(0);
                r_cnt++;
                if (first_r_cyc < 0) first_r_cyc = cyc;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(m_axi_arlen);
                for (int i = 0; i <= int'(m_axi_arlen); i++) begin
                    rq.push_back(m_axi_araddr + 64'(64 * i));
                    rq_last.push_back(i == int'(m_axi_arlen));
                end
            end
            if (data_tvalid && data_tready) begin
                pop_data_q.push_back(data_tdata[63:0]);
                pop_last_q.push_back(data_tlast);
                last_pop_cyc = cyc;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            if (read_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_xfer(input logic [63:0] addr, input logic [31:0] size);
        @(negedge kernel_clk);
        ar_addr_q.delete();
        ar_len_q.delete();
        pop_data_q.delete();
        pop_last_q.delete();
        done_cnt = 0;
        r_cnt    = 0;
        dram_xfer_start_addr    = addr;
        dram_xfer_size_in_bytes = size;
        read_start = 1'b1;
        @(negedge kernel_clk);
        read_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge kernel_clk);
            n++;
        end
        repeat (5) @(negedge kernel_clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: read_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        kernel_rst_n = 1'b0;
        repeat (3) @(negedge kernel_clk);
        #2;
        checks++;
        if ({read_done, m_axi_arvalid, m_axi_rready, data_tvalid, data_tlast} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {read_done, m_axi_arvalid, m_axi_rready, data_tvalid, data_tlast});
        end
        checks++;
        if (m_axi_araddr !== 64'h0 || m_axi_arlen !== 8'h0) begin
            errors++;
            $display("FAIL reset_ar: got addr %h len %h required 0 0", m_axi_araddr, m_axi_arlen);
        end
        checks++;
        if (data_tdata !== 512'h0) begin
            errors++;
            $display("FAIL reset_tdata: got nonzero required 0");
        end
        @(negedge kernel_clk);
        kernel_rst_n = 1'b1;
        @(negedge kernel_clk);
    endtask

    task automatic test_single_beat();
        tready_en = 1'b1;
        start_xfer(64'h1000, 32'd64);
        wait_done(100, "single");
        checks++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 64'h1000 || ar_len_q[0] !== 8'd0) begin
            errors++;
            $display("FAIL single_ar: got %0d ARs required one AR at 1000 len 0", ar_addr_q.size());
        end
        checks++;
        if (pop_data_q.size() != 1 || pop_data_q[0] !== 64'h1000 || pop_last_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_beat: got %0d beats required 1 beat data 1000 tlast", pop_data_q.size());
        end
        checks++;
        if (first_ar_cyc - start_cyc != 1) begin
            errors++;
            $display("FAIL single_ar_latency: got %0d required 1", first_ar_cyc - start_cyc);
        end
        checks++;
        if (first_tv_cyc - first_r_cyc != 1) begin
            errors++;
            $display("FAIL single_r_latency: got %0d required 1", first_tv_cyc - first_r_cyc);
        end
        checks++;
        if (done_cyc - last_pop_cyc != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL single_done: got delay %0d count %0d required 1 1",
                     done_cyc - last_pop_cyc, done_cnt);
        end
    endtask

    task automatic test_multi_burst();
        int bad = 0;
        int lasts = 0;
        tready_en = 1'b1;
        start_xfer(64'h0, 32'd8192);
        wait_done(400, "multi");
        checks++;
        if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 64'h0 || ar_len_q[0] !== 8'd63 ||
            ar_addr_q[1] !== 64'h1000 || ar_len_q[1] !== 8'd63) begin
            errors++;
            $display("FAIL multi_ar: got %0d ARs required (0,63) (1000,63)", ar_addr_q.size());
        end
        for (int i = 0; i < pop_data_q.size(); i++) begin
            if (pop_data_q[i] !== 64'(64 * i)) bad++;
            if (pop_last_q[i]) lasts++;
        end
        checks++;
        if (pop_data_q.size() != 128 || bad != 0) begin
            errors++;
            $display("FAIL multi_data: got %0d beats %0d wrong required 128 0", pop_data_q.size(), bad);
        end
        checks++;
        if (lasts != 1 || pop_last_q[pop_last_q.size()-1] !== 1'b1) begin
            errors++;
            $display("FAIL multi_tlast: got %0d tlast required 1 on beat 128", lasts);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL multi_done_count: got %0d required 1", done_cnt);
        end
        checks++;
        if (last_pop_cyc - first_pop_cyc != 127) begin
            errors++;
            $display("FAIL multi_throughput: got span %0d required 127", last_pop_cyc - first_pop_cyc);
        end
    endtask

    task automatic test_4k_boundary();
        int bad = 0;
        tready_en = 1'b1;
        start_xfer(64'hF80, 32'd512);
        wait_done(100, "page");
        checks++;
        if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 64'hF80 || ar_len_q[0] !== 8'd1 ||
            ar_addr_q[1] !== 64'h1000 || ar_len_q[1] !== 8'd5) begin
            errors++;
            $display("FAIL page_ar: got %0d ARs required (f80,1) (1000,5)", ar_addr_q.size());
        end
        for (int i = 0; i < pop_data_q.size(); i++)
            if (pop_data_q[i] !== 64'hF80 + 64'(64 * i)) bad++;
        checks++;
        if (pop_data_q.size() != 8 || bad != 0 || pop_last_q[pop_last_q.size()-1] !== 1'b1) begin
            errors++;
            $display("FAIL page_data: got %0d beats %0d wrong required 8 0", pop_data_q.size(), bad);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int lasts = 0;
        tready_en = 1'b0;
        start_xfer(64'h0, 32'd65536);
        repeat (600) @(negedge kernel_clk);
        checks++;
        if (ar_addr_q.size() != 8) begin
            errors++;
            $display("FAIL bp_ar_stall: got %0d ARs required 8", ar_addr_q.size());
        end
        checks++;
        if (r_cnt != 512 || m_axi_rready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fifo_full: got %0d beats rready %b required 512 0", r_cnt, m_axi_rready);
        end
        tready_en = 1'b1;
        wait_done(3000, "bp");
        for (int i = 0; i < pop_data_q.size(); i++) begin
            if (pop_data_q[i] !== 64'(64 * i)) bad++;
            if (pop_last_q[i]) lasts++;
        end
        checks++;
        if (pop_data_q.size() != 1024 || bad != 0 || r_cnt != 1024) begin
            errors++;
            $display("FAIL bp_data: got %0d beats %0d wrong %0d R required 1024 0 1024",
                     pop_data_q.size(), bad, r_cnt);
        end
        checks++;
        if (ar_addr_q.size() != 16 || lasts != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_totals: got %0d ARs %0d tlast %0d done required 16 1 1",
                     ar_addr_q.size(), lasts, done_cnt);
        end
    endtask

    task automatic test_odd_zero();
        tready_en = 1'b0;
        start_xfer(64'h47, 32'd100);
        repeat (3) @(negedge kernel_clk);
        dram_xfer_start_addr    = 64'h9000;
        dram_xfer_size_in_bytes = 32'd4096;
        read_start = 1'b1;
        @(negedge kernel_clk);
        read_start = 1'b0;
        repeat (3) @(negedge kernel_clk);
        tready_en = 1'b1;
        wait_done(100, "odd");
        checks++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 64'h40 || ar_len_q[0] !== 8'd1) begin
            errors++;
            $display("FAIL odd_ar: got %0d ARs required one AR at 40 len 1", ar_addr_q.size());
        end
        checks++;
        if (pop_data_q.size() != 2 || pop_data_q[1] !== 64'h80 ||
            pop_last_q[0] !== 1'b0 || pop_last_q[1] !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL odd_beats: got %0d beats %0d done required 2 beats tlast on 2nd 1 done",
                     pop_data_q.size(), done_cnt);
        end
        start_xfer(64'h3000, 32'd0);
        wait_done(20, "zero");
        checks++;
        if (done_cyc - start_cyc != 1 || ar_addr_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_size: got delay %0d ARs %0d done %0d required 1 0 1",
                     done_cyc - start_cyc, ar_addr_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        tready_en = 1'b1;
        start_xfer(64'h0, 32'd4096);
        while (pop_data_q.size() < 10 && n < 200) begin
            @(negedge kernel_clk);
            n++;
        end
        kernel_rst_n = 1'b0;
        #2;
        checks++;
        if ({read_done, m_axi_arvalid, m_axi_rready, data_tvalid, data_tlast} !== 5'b0 ||
            data_tdata !== 512'h0 || m_axi_araddr !== 64'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got ctrl %b required 00000 and zero buses",
                     {read_done, m_axi_arvalid, m_axi_rready, data_tvalid, data_tlast});
        end
        rq.delete();
        rq_last.delete();
        @(negedge kernel_clk);
        kernel_rst_n = 1'b1;
        repeat (3) @(negedge kernel_clk);
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL midreset_done: got %0d read_done required 0", done_cnt);
        end
        start_xfer(64'h2000, 32'd64);
        wait_done(100, "after_reset");
        checks++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 64'h2000 || pop_data_q.size() != 1 ||
            pop_data_q[0] !== 64'h2000 || pop_last_q[0] !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL after_reset_xfer: got %0d ARs %0d beats %0d done required 1 1 1",
                     ar_addr_q.size(), pop_data_q.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_burst();
        test_4k_boundary();
        test_backpressure();
        test_odd_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnn_0_load_axi_read_master.md
# gnn_0_load_axi_read_master

AXI4 read master that sits directly upstream of the load stage. On a `read_start` pulse it splits a DRAM transfer of `dram_xfer_size_in_bytes` starting at `dram_xfer_start_addr` into 4 KB-safe AR bursts. It buffers the returned R beats in an internal FIFO and presents them to the load stage as a `data_tvalid/data_tready/data_tlast` stream. It pulses `read_done` once the last beat has been consumed.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 64, AXI address width.
- `C_M_AXI_DATA_WIDTH`, 512, AXI/stream data width (64 bytes per beat).
- `C_XFER_SIZE_WIDTH`, 32, transfer size width.
- `C_BURST_LEN`, 64, max beats per AR burst (power of 2, ≤256).
- `C_FIFO_DEPTH`, 512, R-data FIFO depth in beats (power of 2, ≥`C_BURST_LEN`).
- `kernel_clk`  in  1  sole clock; all logic on rising edge.
- `kernel_rst_n`  in  1  asynchronous active-low reset.
- `read_start`  in  1  one-cycle start pulse; ignored unless IDLE.
- `dram_xfer_start_addr`  in  C_M_AXI_ADDR_WIDTH  byte address, sampled on `read_start`.
- `dram_xfer_size_in_bytes`  in  C_XFER_SIZE_WIDTH  byte count, sampled on `read_start`.
- `read_done`  out  1  one-cycle pulse at end of transfer.
- `m_axi_arvalid` out 1; `m_axi_arready` in 1; `m_axi_araddr` out C_M_AXI_ADDR_WIDTH; `m_axi_arlen` out 8  AR channel.
- `m_axi_rvalid` in 1; `m_axi_rready` out 1; `m_axi_rdata` in C_M_AXI_DATA_WIDTH; `m_axi_rlast` in 1  R channel.
- `data_tvalid` out 1; `data_tready` in 1; `data_tlast` out 1; `data_tdata` out C_M_AXI_DATA_WIDTH  stream to load stage.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE + `read_start`:
  - latch `addr = start_addr & ~63`.
  - latch `beats = (size + 63) >> 6`, computed on C_XFER_SIZE_WIDTH+1 bits.
  - clear counters; go to RUN.
  - If `beats == 0`, go to FINISH instead; no AR is issued.
- AR issue, RUN:
  - Burst length `n = min(remaining_ar_beats, C_BURST_LEN, (4096 - addr[11:0]) >> 6)`.
  - Drive `arlen = n-1` and `araddr = addr`.
  - Assert `arvalid` only when `credits >= n`.
  - `araddr`/`arlen` are held stable while `arvalid && !arready`.
  - On handshake: `addr += n*64`, `remaining_ar_beats -= n`, `credits -= n`.
- Credits:
  - Reset/start value is `C_FIFO_DEPTH`.
  - `+1` per stream pop (`data_tvalid && data_tready`).
  - Simultaneous AR handshake and pop apply both (`credits - n + 1`).
  - The credit scheme guarantees the FIFO never overflows.
- R path:
  - `m_axi_rready = (state==RUN) && !fifo_full`.
  - Every R handshake writes `rdata` into the FIFO.
  - `m_axi_rlast` is not used for framing.
- Stream:
  - FIFO is first-word-fall-through; `data_tvalid = !fifo_empty`.
  - `data_tlast` is high on the beat whose pop count equals `beats`.
  - Bytes past `size` in the final beat are passed unmodified.
- After the pop of beat number `beats`, go to FINISH.
- FINISH: `read_done = 1` for exactly one cycle, then IDLE.
- `read_start` in RUN/FINISH is ignored, with no side effects.

## Timing
- Reset values:
  - Outputs: `read_done`, `m_axi_arvalid`, `m_axi_araddr`, `m_axi_arlen`, `m_axi_rready`, `data_tvalid`, `data_tlast` all 0; `data_tdata` = 0.
  - Internal: state IDLE, FIFO empty, credits `C_FIFO_DEPTH`.
- Reset mid-transfer aborts immediately: FIFO flushed, no `read_done`. Outstanding AXI responses are the system's responsibility.
- `read_start` in cycle 0 → first `arvalid` in cycle 1.
- R beat accepted in cycle k → visible on `data_tvalid` in cycle k+1.
- Final pop in cycle m → `read_done` high in cycle m+1.
- Size 0: `read_start` in cycle 0 → `read_done` in cycle 1.
- Sustained throughput: one beat/cycle when `arready`, `rvalid` and `tready` are all held high.

## Test plan
- Single beat: addr 0x1000, size 64 → one AR (0x1000, arlen 0); one beat with `tlast`; `read_done` one cycle after the pop.
- Multi-burst: addr 0x0, size 8192 → AR (0x0, 63) then AR (0x1000, 63); 128 beats in order; `tlast` only on the 128th; exactly one `read_done`.
- 4 KB boundary: addr 0xF80, size 512 → AR (0xF80, arlen 1) then AR (0x1000, arlen 5); 8 beats total.
- Backpressure: size 65536, `data_tready` low for 600 cycles, slave always ready → exactly 8 ARs issued (512 credits) before stall; no R beat lost; 1024 beats delivered after `tready` rises.
- Odd/zero size:
  - size 100 → 2 beats, `tlast` on the 2nd.
  - size 0 → no AR and `read_done` in cycle 1.
  - `read_start` while RUN → ignored.
- Reset mid-transfer: assert `kernel_rst_n` low after 10 of 64 beats → all outputs 0 in the same cycle. A subsequent start (addr 0x2000, size 64) completes normally.
